// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with modulo limit,
// step size, wrap or saturate mode, enable prescaler and terminal count.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clear     synchronous clear (highest priority)
//   load      synchronous load of load_val, clamped to MAX_VAL
//   load_val  value to load [WIDTH-1:0]
//   enable    count enable, feeds the prescaler
//   up_down   1 = up, 0 = down, sampled on each advance
//   count     registered counter value [WIDTH-1:0]
//   tc        registered pulse, high the cycle after a wrap or clamp
//   wrap_cnt  [7:0] saturating count of tc events, present only when
//             PARAM_COUNTER_WRAP_CNT_EN is defined
//
// Optional feature macro: PARAM_COUNTER_WRAP_CNT_EN

module param_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int STEP     = 1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             tc
`ifdef PARAM_COUNTER_WRAP_CNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);

    // Advance arithmetic is done one bit wider so count+STEP and
    // count+MAX_VAL+1 never overflow.
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MAX_VAL + 1);

    localparam bit SAT = (SATURATE != 0);

    if (MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
        $error("MAX_VAL does not fit in WIDTH bits");
    end
    if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
        $error("STEP must lie in 1..MAX_VAL");
    end
    if (PRESCALE < 1) begin : g_bad_pre
        $error("PRESCALE must be at least 1");
    end

    logic [PW-1:0]    presc;
    logic             pre_roll;

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   sum_x;
    logic             up_hit;
    logic             dn_hit;
    logic [WIDTH-1:0] up_nxt;
    logic [WIDTH-1:0] dn_nxt;
    logic [WIDTH-1:0] adv_val;
    logic             adv_hit;
    logic [WIDTH-1:0] ld_val;

    assign pre_roll = (presc == PRE_LAST);
    assign ld_val   = (load_val > MAX_C) ? MAX_C : load_val;

    always_comb begin
        cnt_x  = {1'b0, count};
        sum_x  = cnt_x + STEP_X;
        up_hit = (sum_x > MAX_X);
        dn_hit = (cnt_x < STEP_X);

        up_nxt = WIDTH'(sum_x);
        if (up_hit) begin
            if (SAT) begin
                up_nxt = MAX_C;
            end else begin
                up_nxt = WIDTH'(sum_x - MOD_X);
            end
        end

        dn_nxt = WIDTH'(cnt_x - STEP_X);
        if (dn_hit) begin
            if (SAT) begin
                dn_nxt = '0;
            end else begin
                dn_nxt = WIDTH'(cnt_x + MOD_X - STEP_X);
            end
        end

        adv_val = up_down ? up_nxt : dn_nxt;
        adv_hit = up_down ? up_hit : dn_hit;
    end

    // tc defaults low every edge so it is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            presc <= '0;
            tc    <= 1'b0;
        end else if (clear) begin
            count <= '0;
            presc <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= ld_val;
            presc <= '0;
            tc    <= 1'b0;
        end else if (enable) begin
            if (pre_roll) begin
                presc <= '0;
                count <= adv_val;
                tc    <= adv_hit;
            end else begin
                presc <= presc + 1'b1;
                tc    <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

`ifdef PARAM_COUNTER_WRAP_CNT_EN
    logic wrap_evt;

    assign wrap_evt = !clear && !load && enable && pre_roll && adv_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt <= 8'd0;
        end else if (clear) begin
            wrap_cnt <= 8'd0;
        end else if (wrap_evt && wrap_cnt != 8'hFF) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: five counter configurations driven by shared
// directed and random stimulus, each checked against a reference model.

module tb_param_updown_counter;

    localparam int N = 5;
    localparam int P_MAX  [N] = '{9, 9, 255, 100, 200};
    localparam int P_STEP [N] = '{1, 4, 1, 7, 13};
    localparam int P_SAT  [N] = '{0, 1, 0, 0, 1};
    localparam int P_PRE  [N] = '{1, 1, 3, 2, 2};

    typedef struct {
        int maxv;
        int step;
        int sat;
        int pre;
    } cfg_t;

    typedef struct {
        int cnt;
        int ph;
        int tc;
        int wc;
    } st_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       enable;
    logic       up_down;
    logic [7:0] cnt [N];
    logic       tcv [N];
`ifdef PARAM_COUNTER_WRAP_CNT_EN
    logic [7:0] wc  [N];
`endif

    cfg_t cfg [N];
    st_t  ms  [N];
    int   n_cmp = 0;
    int   n_bad = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        param_updown_counter #(
            .WIDTH    (8),
            .MAX_VAL  (P_MAX[g]),
            .STEP     (P_STEP[g]),
            .SATURATE (P_SAT[g]),
            .PRESCALE (P_PRE[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .load     (load),
            .load_val (load_val),
            .enable   (enable),
            .up_down  (up_down),
            .count    (cnt[g]),
            .tc       (tcv[g])
`ifdef PARAM_COUNTER_WRAP_CNT_EN
            ,
            .wrap_cnt (wc[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Next state from the behavioural rules, in plain integers.
    function automatic st_t model(cfg_t c, st_t s, bit clr, bit ld,
                                  int lv, bit en, bit ud);
        st_t n;
        int  t;
        bit  hit;
        n    = s;
        n.tc = 0;
        hit  = 0;
        if (clr) begin
            n.cnt = 0;
            n.ph  = 0;
            n.wc  = 0;
        end else if (ld) begin
            n.cnt = (lv > c.maxv) ? c.maxv : lv;
            n.ph  = 0;
        end else if (en) begin
            n.ph = s.ph + 1;
            if (n.ph == c.pre) begin
                n.ph = 0;
                if (ud) begin
                    t = s.cnt + c.step;
                    if (t > c.maxv) begin
                        hit = 1;
                        t = c.sat ? c.maxv : t - (c.maxv + 1);
                    end
                end else begin
                    t = s.cnt - c.step;
                    if (t < 0) begin
                        hit = 1;
                        t = c.sat ? 0 : t + c.maxv + 1;
                    end
                end
                n.cnt = t;
                n.tc  = hit;
                if (hit && n.wc < 255) n.wc = n.wc + 1;
            end
        end
        return n;
    endfunction

    task automatic check_all(string what);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s cnt[%0d]", what, i), cnt[i], ms[i].cnt);
            check($sformatf("%s tc[%0d]", what, i), tcv[i], ms[i].tc);
`ifdef PARAM_COUNTER_WRAP_CNT_EN
            check($sformatf("%s wc[%0d]", what, i), wc[i], ms[i].wc);
`endif
        end
    endtask

    task automatic step(bit c, bit l, int v, bit e, bit u);
        clear    = c;
        load     = l;
        load_val = 8'(v);
        enable   = e;
        up_down  = u;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            ms[i] = model(cfg[i], ms[i], c, l, v, e, u);
        end
        #1;
        check_all("model");
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) ms[i] = '{0, 0, 0, 0};
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            cfg[i] = '{P_MAX[i], P_STEP[i], P_SAT[i], P_PRE[i]};
        end
        reset_model();
        rst_n    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
        enable   = 1'b0;
        up_down  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // modulo-10 up across the limit
        step(0, 1, 7, 0, 1);
        check("m10 load7", cnt[0], 7);
        step(0, 0, 0, 1, 1);
        check("m10 up8", cnt[0], 8);
        check("m10 up8 tc", tcv[0], 0);
        step(0, 0, 0, 1, 1);
        check("m10 up9", cnt[0], 9);
        check("m10 up9 tc", tcv[0], 0);
        step(0, 0, 0, 1, 1);
        check("m10 wrap0", cnt[0], 0);
        check("m10 wrap0 tc", tcv[0], 1);
        step(0, 0, 0, 0, 1);
        check("m10 idle tc", tcv[0], 0);

        // modulo-10 down across zero
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("m10 dn0", cnt[0], 0);
        check("m10 dn0 tc", tcv[0], 0);
        step(0, 0, 0, 1, 0);
        check("m10 dn9", cnt[0], 9);
        check("m10 dn9 tc", tcv[0], 1);

        // load clamp and priority
        step(0, 1, 200, 0, 1);
        check("m10 clamp", cnt[0], 9);
        step(1, 1, 5, 0, 1);
        check("clear>load", cnt[0], 0);
        step(0, 1, 5, 1, 1);
        check("load>enable", cnt[0], 5);
        check("load>enable tc", tcv[0], 0);

        // saturate, step 4
        step(0, 1, 3, 0, 1);
        step(0, 0, 0, 1, 1);
        check("sat 7", cnt[1], 7);
        check("sat 7 tc", tcv[1], 0);
        step(0, 0, 0, 1, 1);
        check("sat 9", cnt[1], 9);
        check("sat 9 tc", tcv[1], 1);
        step(0, 0, 0, 1, 1);
        check("sat hold 9", cnt[1], 9);
        check("sat hold 9 tc", tcv[1], 1);
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 0);
        check("sat dn 0", cnt[1], 0);
        check("sat dn 0 tc", tcv[1], 1);

        // prescale by 3
        step(1, 0, 0, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 0, 1, 1);
            if (k % 3 == 0) check($sformatf("pre c%0d", k), cnt[2], k / 3);
        end
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        check("pre held", cnt[2], 3);
        step(0, 0, 0, 1, 1);
        check("pre resume", cnt[2], 4);
        step(0, 0, 0, 1, 1);
        step(0, 1, 10, 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("pre load ph", cnt[2], 10);
        step(0, 0, 0, 1, 1);
        check("pre load adv", cnt[2], 11);

        // three wraps of the modulo-10 instance
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 30; k++) step(0, 0, 0, 1, 1);
        check("m10 30 adv", cnt[0], 0);
`ifdef PARAM_COUNTER_WRAP_CNT_EN
        check("wc 3 wraps", wc[0], 3);
        step(0, 1, 4, 0, 1);
        check("wc after load", wc[0], 3);
        step(1, 0, 0, 0, 1);
        check("wc cleared", wc[0], 0);
`endif

        // random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 32) == 0, ($urandom % 16) == 0,
                 $urandom_range(0, 255), ($urandom % 4) != 0,
                 $urandom % 2);
        end

        // asynchronous reset between edges while tc is high
        step(0, 1, 9, 0, 1);
        step(0, 0, 0, 1, 1);
        check("pre-reset tc", tcv[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all("async rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            step(0, ($urandom % 16) == 0, $urandom_range(0, 255),
                 ($urandom % 4) != 0, $urandom % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
